// File: rtl/mod5_pkg.sv
// Shared types and the mod-5 remainder transition function for the
// mod5_word_checker block and its residue core.
package mod5_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef logic [2:0] rem_t;

    localparam rem_t REM_ZERO = 3'd0;

    // Appending bit b to a value with remainder r gives remainder (2r + b) mod 5.
    // Codes 5..7 cannot occur in normal operation and restart from 0.
    function automatic rem_t next_rem(input rem_t r, input logic b);
        rem_t n;
        case (r)
            3'd0:    n = b ? 3'd1 : 3'd0;
            3'd1:    n = b ? 3'd3 : 3'd2;
            3'd2:    n = b ? 3'd0 : 3'd4;
            3'd3:    n = b ? 3'd2 : 3'd1;
            3'd4:    n = b ? 3'd4 : 3'd3;
            default: n = b ? 3'd1 : 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mod5_residue_core.sv
// Registered serial mod-5 remainder tracker: one bit consumed per enabled
// clock, MSB first; clr_i restarts the remainder at zero.
module mod5_residue_core
    import mod5_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    input  logic bit_i,
    output rem_t rem_o
);

    rem_t rem_q;
    rem_t rem_d;

    // Next remainder: clear has priority over the shift step.
    always_comb begin
        rem_d = rem_q;
        if (clr_i) begin
            rem_d = REM_ZERO;
        end else if (en_i) begin
            rem_d = next_rem(rem_q, bit_i);
        end
    end

    // Remainder register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= REM_ZERO;
        end else begin
            rem_q <= rem_d;
        end
    end

    assign rem_o = rem_q;

endmodule

// File: rtl/mod5_word_checker.sv
// Word-level controller around mod5_residue_core. Accepts WIDTH-bit words over
// a valid/ready handshake, feeds them MSB-first into the residue core and
// presents remainder / divisible-by-5 over an output valid/ready handshake.
// Optional build macro MOD5_STATS_EN adds a saturating 16-bit count of
// delivered results that were divisible by 5 (port div_count_o).
module mod5_word_checker
    import mod5_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [2:0]       out_rem_o,
    output logic             out_div5_o,
    output logic             busy_o
`ifdef MOD5_STATS_EN
    ,
    output logic [15:0]      div_count_o
`endif
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             state_q,    state_d;
    logic [WIDTH-1:0]   shreg_q,    shreg_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    rem_t               out_rem_q,  out_rem_d;
    logic               out_div5_q, out_div5_d;

    logic accept;
    logic shift_en;
    logic msb;
    rem_t rem;
    rem_t rem_nxt;

    // A new word may enter while idle, or while a finished result is being
    // taken on this very edge (back-to-back without a bubble).
    assign in_ready_o = (state_q == IDLE) || ((state_q == DONE) && out_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign shift_en   = (state_q == SHIFT);
    assign msb        = shreg_q[WIDTH-1];
    assign rem_nxt    = next_rem(rem, msb);

    mod5_residue_core u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (accept),
        .en_i  (shift_en),
        .bit_i (msb),
        .rem_o (rem)
    );

    // Next-state, shift register, bit counter and result capture.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        out_rem_d  = out_rem_q;
        out_div5_d = out_div5_q;
        case (state_q)
            SHIFT: begin
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    // Last bit consumed: the result is the remainder after this bit.
                    cnt_d      = '0;
                    out_rem_d  = rem_nxt;
                    out_div5_d = (rem_nxt == REM_ZERO);
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
            end
        endcase
        // Accept can only happen from IDLE or DONE, so it overrides the above.
        if (accept) begin
            shreg_d = in_data_i;
            cnt_d   = CNT_W'(WIDTH - 1);
            state_d = SHIFT;
        end
    end

    // Control and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            out_rem_q  <= REM_ZERO;
            out_div5_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            out_rem_q  <= out_rem_d;
            out_div5_q <= out_div5_d;
        end
    end

    assign out_valid_o = (state_q == DONE);
    assign out_rem_o   = out_rem_q;
    assign out_div5_o  = out_div5_q;
    assign busy_o      = (state_q != IDLE);

`ifdef MOD5_STATS_EN
    logic [15:0] div_count_q, div_count_d;

    // Count delivered divisible results, sticking at the maximum.
    always_comb begin
        div_count_d = div_count_q;
        if (out_valid_o && out_ready_i && out_div5_q && (div_count_q != 16'hFFFF)) begin
            div_count_d = div_count_q + 16'd1;
        end
    end

    // Statistics register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_count_q <= '0;
        end else begin
            div_count_q <= div_count_d;
        end
    end

    assign div_count_o = div_count_q;
`endif

endmodule

// File: tb/tb_mod5_word_checker.sv
// Self-checking bench for mod5_word_checker (WIDTH=8): table vectors,
// hand-written handshake/reset sequences and random words against word % 5.
module tb_mod5_word_checker;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid_i;
    logic [WIDTH-1:0] in_data_i;
    logic             in_ready_o;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [2:0]       out_rem_o;
    logic             out_div5_o;
    logic             busy_o;
`ifdef MOD5_STATS_EN
    logic [15:0]      div_count_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    mod5_word_checker #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_rem_o   (out_rem_o),
        .out_div5_o  (out_div5_o),
        .busy_o      (busy_o)
`ifdef MOD5_STATS_EN
        ,
        .div_count_o (div_count_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         exp_rem;
        int         exp_div;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string nm);
        chk({nm, "_valid"}, int'(out_valid_o), 0);
        chk({nm, "_rem"},   int'(out_rem_o),   0);
        chk({nm, "_div5"},  int'(out_div5_o),  1);
        chk({nm, "_busy"},  int'(busy_o),      0);
        chk({nm, "_ready"}, int'(in_ready_o),  1);
    endtask

    // Wait (bounded) for out_valid_o; returns cycles elapsed since the last step.
    task automatic wait_result(output int lat);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (out_valid_o) begin
                lat = k;
                break;
            end
        end
    endtask

    // Full single-word transaction from IDLE with an optional output stall.
    task automatic do_word(input logic [7:0] d, input int exp_rem, input int stall,
                           input string nm);
        int lat;
        in_valid_i  = 1'b1;
        in_data_i   = d;
        out_ready_i = (stall == 0);
        #1;
        chk({nm, "_in_ready"}, int'(in_ready_o), 1);
        step();
        in_valid_i = 1'b0;
        in_data_i  = 8'($urandom);
        wait_result(lat);
        chk({nm, "_latency"}, lat, WIDTH);
        chk({nm, "_rem"}, int'(out_rem_o), exp_rem);
        chk({nm, "_div5"}, int'(out_div5_o), int'(exp_rem == 0));
        for (int s = 0; s < stall; s++) begin
            step();
            if (!out_valid_o || out_rem_o != 3'(exp_rem)) begin
                chk({nm, "_stall_hold"}, {29'd0, out_valid_o, out_rem_o[1:0]} , {29'd0, 1'b1, 2'(exp_rem)});
            end
        end
        out_ready_i = 1'b1;
        step();
        chk({nm, "_idle_valid"}, int'(out_valid_o), 0);
        chk({nm, "_idle_busy"}, int'(busy_o), 0);
    endtask

    initial begin
        int lat;
        logic [7:0] rw;

        vecs[0]  = '{8'h0A, 0, 1};
        vecs[1]  = '{8'hFF, 0, 1};
        vecs[2]  = '{8'hFE, 4, 0};
        vecs[3]  = '{8'h07, 2, 0};
        vecs[4]  = '{8'h19, 0, 1};
        vecs[5]  = '{8'h0D, 3, 0};
        vecs[6]  = '{8'h14, 0, 1};
        vecs[7]  = '{8'h33, 1, 0};
        vecs[8]  = '{8'h00, 0, 1};
        vecs[9]  = '{8'h01, 1, 0};
        vecs[10] = '{8'h80, 3, 0};
        vecs[11] = '{8'h7F, 2, 0};

        rst_n       = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        out_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values("reset");
        rst_n = 1'b1;
        step();
        chk_reset_values("post_reset");

        // Table vectors.
        for (int i = 0; i < 12; i++) begin
            do_word(vecs[i].data, vecs[i].exp_rem, 0, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_div_tbl", i), int'(out_div5_o), vecs[i].exp_div);
        end

        // Back-to-back: 7 then 25 with in_valid_i held high.
        in_valid_i  = 1'b1;
        in_data_i   = 8'd7;
        out_ready_i = 1'b1;
        step();
        in_data_i = 8'd25;
        wait_result(lat);
        chk("b2b_first_latency", lat, WIDTH);
        chk("b2b_first_rem", int'(out_rem_o), 2);
        chk("b2b_in_ready_done", int'(in_ready_o), 1);
        step();
        chk("b2b_no_idle_busy", int'(busy_o), 1);
        chk("b2b_no_idle_valid", int'(out_valid_o), 0);
        in_valid_i = 1'b0;
        wait_result(lat);
        chk("b2b_second_latency", lat, WIDTH);
        chk("b2b_second_rem", int'(out_rem_o), 0);
        chk("b2b_second_div5", int'(out_div5_o), 1);
        step();

        // Output stall: result for 13 held 5 cycles while 20 waits.
        in_valid_i  = 1'b1;
        in_data_i   = 8'd13;
        out_ready_i = 1'b0;
        step();
        in_valid_i = 1'b0;
        wait_result(lat);
        chk("stall_latency", lat, WIDTH);
        in_valid_i = 1'b1;
        in_data_i  = 8'd20;
        for (int s = 0; s < 5; s++) begin
            chk($sformatf("stall%0d_valid", s), int'(out_valid_o), 1);
            chk($sformatf("stall%0d_rem", s), int'(out_rem_o), 3);
            chk($sformatf("stall%0d_div5", s), int'(out_div5_o), 0);
            chk($sformatf("stall%0d_in_ready", s), int'(in_ready_o), 0);
            step();
        end
        out_ready_i = 1'b1;
        #1;
        chk("stall_release_in_ready", int'(in_ready_o), 1);
        step();
        in_valid_i = 1'b0;
        chk("stall_accept_busy", int'(busy_o), 1);
        wait_result(lat);
        chk("stall_second_latency", lat, WIDTH);
        chk("stall_second_rem", int'(out_rem_o), 0);
        step();

        // Reset in the middle of a word.
        in_valid_i = 1'b1;
        in_data_i  = 8'h33;
        step();
        in_valid_i = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        chk_reset_values("midrst");
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        lat = 0;
        for (int k = 0; k < WIDTH + 3; k++) begin
            step();
            if (out_valid_o) lat++;
        end
        chk("midrst_no_result", lat, 0);
        do_word(8'h05, 0, 0, "after_rst");

        // Random words with random output stalls against word % 5.
        for (int i = 0; i < 40; i++) begin
            rw = 8'($urandom);
            do_word(rw, int'(rw) % 5, int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
        end

`ifdef MOD5_STATS_EN
        rst_n = 1'b0;
        #2;
        chk("stats_reset", int'(div_count_o), 0);
        rst_n = 1'b1;
        step();
        do_word(8'd5,  0, 0, "stats5");
        do_word(8'd6,  1, 0, "stats6");
        do_word(8'd10, 0, 0, "stats10");
        do_word(8'd0,  0, 0, "stats0");
        chk("stats_count", int'(div_count_o), 3);
        force dut.div_count_q = 16'hFFFE;
        #1;
        release dut.div_count_q;
        do_word(8'd15, 0, 0, "sat1");
        chk("stats_reach_max", int'(div_count_o), 16'hFFFF);
        do_word(8'd20, 0, 0, "sat2");
        chk("stats_saturate", int'(div_count_o), 16'hFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
